// File: rtl/syscall_sequencer.sv
// Multi-cycle syscall service sequencer: decodes V0/A0 at writeback, stalls the pipeline,
// and streams integers, characters and memory strings onto valid/ready console ports.
module syscall_sequencer #(
    parameter int MAX_STR_LEN = 256,
    parameter bit BIG_ENDIAN  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Syscall,
    input  logic [31:0] V0,
    input  logic [31:0] A0,
    output logic [31:0] StrPrintAddr,
    input  logic [31:0] StrPrint,
    output logic        CharValid,
    output logic [7:0]  CharData,
    input  logic        CharReady,
    output logic        IntValid,
    output logic [31:0] IntData,
    input  logic        IntReady,
    output logic        Stall,
    output logic        Halt,
    output logic        BadSyscall,
    output logic        Truncated
);

    localparam int CntWidth = $clog2(MAX_STR_LEN + 1);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(MAX_STR_LEN - 1);

    typedef enum logic [2:0] {IDLE, INT, CHAR, STR, HALT} state_t;

    state_t              state;
    logic [31:0]         ptr;
    logic [31:0]         arg;
    logic [CntWidth-1:0] cnt;

    logic [1:0] lane;
    logic [7:0] strByte;
    logic       knownCode;
    logic       strHandshake;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
        lane         = BIG_ENDIAN ? ~ptr[1:0] : ptr[1:0];
        strByte      = StrPrint[{lane, 3'b000} +: 8];
        knownCode    = (V0 == 32'd1) || (V0 == 32'd4) || (V0 == 32'd10) || (V0 == 32'd11);
        strHandshake = (state == STR) && (strByte != 8'h00) && CharReady;

        Stall        = (state != IDLE) || (Syscall && knownCode);
        Halt         = (state == HALT);
        BadSyscall   = (state == IDLE) && Syscall && !knownCode;
        Truncated    = strHandshake && (cnt == LastCnt);
        StrPrintAddr = 32'd0;
        CharValid    = 1'b0;
        CharData     = 8'd0;
        IntValid     = 1'b0;
        IntData      = 32'd0;

        case (state)
            INT: begin
                IntValid = 1'b1;
                IntData  = arg;
            end
            CHAR: begin
                CharValid = 1'b1;
                CharData  = arg[7:0];
            end
            STR: begin
                // The terminator byte reads as zero, so CharData stays 0 when nothing is offered.
                StrPrintAddr = {ptr[31:2], 2'b00};
                CharValid    = (strByte != 8'h00);
                CharData     = strByte;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= IDLE;
            ptr   <= 32'd0;
            arg   <= 32'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Syscall) begin
                        case (V0)
                            32'd1: begin
                                state <= INT;
                                arg   <= A0;
                            end
                            32'd4: begin
                                state <= STR;
                                ptr   <= A0;
                                cnt   <= '0;
                            end
                            32'd11: begin
                                state <= CHAR;
                                arg   <= A0;
                            end
                            32'd10:  state <= HALT;
                            default: ;
                        endcase
                    end
                end
                INT:  if (IntReady) state <= IDLE;
                CHAR: if (CharReady) state <= IDLE;
                STR: begin
                    if (strByte == 8'h00) begin
                        state <= IDLE;
                    end else if (CharReady) begin
                        ptr <= ptr + 32'd1;
                        cnt <= cnt + CntWidth'(1);
                        if (cnt == LastCnt) state <= IDLE;
                    end
                end
                HALT:    ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_sequencer.sv
// Randomized bench for syscall_sequencer: each service's console output, stall length and
// pulses are compared with a transaction-level expectation derived from memory contents.
module tb_syscall_sequencer;

    localparam int MaxLen = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Syscall;
    logic [31:0] V0;
    logic [31:0] A0;
    logic [31:0] StrPrintAddr;
    logic [31:0] StrPrint;
    logic        CharValid;
    logic [7:0]  CharData;
    logic        CharReady;
    logic        IntValid;
    logic [31:0] IntData;
    logic        IntReady;
    logic        Stall;
    logic        Halt;
    logic        BadSyscall;
    logic        Truncated;

    logic [7:0]  mem [4096];
    logic [11:0] memBase;

    int vectors = 0;
    int miscompares = 0;

    int          stallCnt, waitCnt, truncCnt, badCnt, haltCnt;
    logic        lastStall;
    logic        heldChar, heldInt;
    logic [7:0]  heldCharData;
    logic [31:0] heldIntData;
    logic [7:0]  gotChars [$];
    logic [31:0] gotInts [$];
    logic [31:0] addrQ [$];

    always #5 clk = ~clk;

    assign memBase  = {StrPrintAddr[11:2], 2'b00};
    assign StrPrint = {mem[memBase + 12'd3], mem[memBase + 12'd2], mem[memBase + 12'd1], mem[memBase]};

    syscall_sequencer #(.MAX_STR_LEN(MaxLen), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst(rst), .Syscall(Syscall), .V0(V0), .A0(A0),
        .StrPrintAddr(StrPrintAddr), .StrPrint(StrPrint),
        .CharValid(CharValid), .CharData(CharData), .CharReady(CharReady),
        .IntValid(IntValid), .IntData(IntData), .IntReady(IntReady),
        .Stall(Stall), .Halt(Halt), .BadSyscall(BadSyscall), .Truncated(Truncated)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic resetMonitor();
        stallCnt = 0; waitCnt = 0; truncCnt = 0; badCnt = 0; haltCnt = 0;
        heldChar = 1'b0; heldInt = 1'b0; lastStall = 1'b0;
        gotChars.delete(); gotInts.delete(); addrQ.delete();
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are observed 2 units later.
    task automatic cycle();
        #2;
        lastStall = Stall;
        if (Stall) stallCnt++;
        if (Halt && Stall) haltCnt++;
        if (CharValid && !CharReady) waitCnt++;
        if (IntValid && !IntReady) waitCnt++;
        if (CharValid && CharReady) gotChars.push_back(CharData);
        if (IntValid && IntReady) gotInts.push_back(IntData);
        if (Truncated) truncCnt++;
        if (BadSyscall) badCnt++;
        if (!CharValid) check("charIdleZero", CharData, 0);
        if (!IntValid) check("intIdleZero", IntData, 0);
        if (StrPrintAddr != 0 && (addrQ.size() == 0 || addrQ[$] != StrPrintAddr))
            addrQ.push_back(StrPrintAddr);
        if (heldChar) check("charHold", {CharValid, CharData}, {1'b1, heldCharData});
        if (heldInt) check("intHold", {IntValid, IntData}, {1'b1, heldIntData});
        heldChar = CharValid && !CharReady;  heldCharData = CharData;
        heldInt  = IntValid && !IntReady;    heldIntData  = IntData;
        @(posedge clk);
        #1;
    endtask

    task automatic fillMem();
        for (int i = 0; i < 4096; i++)
            mem[i] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
    endtask

    task automatic runService(input logic [31:0] v0, input logic [31:0] a0,
                              input int readyPct, input int holdOff);
        logic [7:0]  expChars [$];
        logic [31:0] expInts [$];
        logic [7:0]  b;
        int expBad, expTrunc, expStall, n;
        bit isStr;

        expBad = 0; expTrunc = 0; isStr = 0;
        case (v0)
            32'd1:  expInts.push_back(a0);
            32'd11: expChars.push_back(a0[7:0]);
            32'd4: begin
                isStr = 1;
                for (int i = 0; i < MaxLen; i++) begin
                    b = mem[12'(a0 + 32'(i))];
                    if (b == 8'h00) break;
                    expChars.push_back(b);
                end
                expTrunc = (expChars.size() == MaxLen) ? 1 : 0;
            end
            default: expBad = 1;
        endcase

        resetMonitor();
        Syscall = 1'b1; V0 = v0; A0 = a0;
        CharReady = ($urandom_range(99) < readyPct); IntReady = ($urandom_range(99) < readyPct);
        cycle();
        Syscall = 1'b0; V0 = $urandom; A0 = $urandom;
        n = 0;
        while (lastStall && n < 200) begin
            n++;
            CharReady = (n <= holdOff) ? 1'b0 : ($urandom_range(99) < readyPct);
            IntReady  = (n <= holdOff) ? 1'b0 : ($urandom_range(99) < readyPct);
            cycle();
        end
        check("serviceTimeout", lastStall, 0);

        expStall = expBad ? 0 : 1 + expChars.size() + expInts.size() + waitCnt
                   + ((isStr && expTrunc == 0) ? 1 : 0);
        check("badPulse", badCnt, expBad);
        check("charCount", gotChars.size(), expChars.size());
        for (int i = 0; i < expChars.size() && i < gotChars.size(); i++)
            check("charData", gotChars[i], expChars[i]);
        check("intCount", gotInts.size(), expInts.size());
        for (int i = 0; i < expInts.size() && i < gotInts.size(); i++)
            check("intData", gotInts[i], expInts[i]);
        check("truncPulse", truncCnt, expTrunc);
        check("stallCycles", stallCnt, expStall);
    endtask

    initial begin
        logic [31:0] rv0;
        int n;

        rst = 1'b1; Syscall = 1'b0; V0 = '0; A0 = '0; CharReady = 1'b0; IntReady = 1'b0;
        fillMem();
        resetMonitor();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("rstStall", Stall, 0);
        check("rstHalt", Halt, 0);
        check("rstValids", {CharValid, IntValid, BadSyscall, Truncated}, 0);
        check("rstData", {StrPrintAddr, CharData}, 0);
        @(posedge clk); #1;

        // Print integer and character.
        runService(32'd1, 32'h0000_002A, 100, 0);
        runService(32'd11, 32'h0000_0137, 100, 2);

        // "Hi" at 0x100.
        mem[12'h100] = 8'h48; mem[12'h101] = 8'h69; mem[12'h102] = 8'h00; mem[12'h103] = 8'h00;
        runService(32'd4, 32'h100, 100, 0);

        // Unaligned "ABC" at 0x103 with three refused cycles on 'A'.
        mem[12'h103] = 8'h41; mem[12'h104] = 8'h42; mem[12'h105] = 8'h43; mem[12'h106] = 8'h00;
        runService(32'd4, 32'h103, 100, 3);
        check("addrCount", addrQ.size(), 2);
        if (addrQ.size() == 2) begin
            check("addrFirst", addrQ[0], 32'h100);
            check("addrSecond", addrQ[1], 32'h104);
        end

        // Ten non-zero bytes: truncated at MaxLen.
        for (int i = 0; i < 10; i++) mem[12'h300 + 12'(i)] = 8'h61 + 8'(i);
        runService(32'd4, 32'h300, 100, 0);

        // Pointer wraps from 0xFFFFFFFF to 0.
        mem[12'hFFE] = 8'h78; mem[12'hFFF] = 8'h79; mem[12'h000] = 8'h7A; mem[12'h001] = 8'h00;
        runService(32'd4, 32'hFFFF_FFFE, 100, 0);

        // Unsupported code.
        runService(32'd99, 32'h0, 100, 0);

        // Randomized services with random backpressure.
        for (int t = 0; t < 40; t++) begin
            fillMem();
            case ($urandom_range(4))
                0: rv0 = 32'd1;
                1: rv0 = 32'd4;
                2: rv0 = 32'd11;
                3: rv0 = 32'd4;
                default: begin
                    rv0 = $urandom;
                    if (rv0 == 32'd10) rv0 = 32'd12;
                end
            endcase
            runService(rv0, $urandom, 60, 0);
        end

        // Reset after the second character of "Hello".
        mem[12'h200] = 8'h48; mem[12'h201] = 8'h65; mem[12'h202] = 8'h6C;
        mem[12'h203] = 8'h6C; mem[12'h204] = 8'h6F; mem[12'h205] = 8'h00;
        resetMonitor();
        Syscall = 1'b1; V0 = 32'd4; A0 = 32'h200; CharReady = 1'b1;
        cycle();
        Syscall = 1'b0;
        n = 0;
        while (gotChars.size() < 2 && n < 20) begin
            n++;
            cycle();
        end
        check("helloTwoChars", gotChars.size(), 2);
        rst = 1'b1; CharReady = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; CharReady = 1'b1;
        #2;
        check("midRstCharValid", CharValid, 0);
        check("midRstStall", Stall, 0);
        @(posedge clk); #1;
        resetMonitor();
        for (int i = 0; i < 5; i++) cycle();
        check("midRstNoChars", gotChars.size(), 0);
        runService(32'd11, 32'h21, 100, 0);

        // Exit: Halt and Stall sticky, further syscalls ignored, reset clears.
        resetMonitor();
        Syscall = 1'b1; V0 = 32'd10; A0 = '0; IntReady = 1'b1;
        cycle();
        Syscall = 1'b0;
        haltCnt = 0;
        for (int i = 0; i < 25; i++) begin
            Syscall = (i == 10); V0 = 32'd1; A0 = 32'h5;
            cycle();
        end
        Syscall = 1'b0;
        check("haltSticky", haltCnt, 25);
        check("haltIgnoresSyscall", gotInts.size(), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("haltCleared", {Halt, Stall}, 0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/syscall_sequencer.md
Name: syscall_sequencer

Overview:
- Multi-cycle controller for syscalls that reach the writeback stage. Decodes V0/A0 and stalls the whole pipeline while the service runs.
- For string printing it steps byte-by-byte through the instruction-memory string port and emits characters on a valid/ready console interface.
- Replaces the combinational syscall/print path and is the only owner of the StrPrintAddr/StrPrint memory port.

Parameters:
- MAX_STR_LEN, 256: maximum characters emitted per print-string. When reached, the string is truncated.
- BIG_ENDIAN, 0: byte lane select. 0 means byte offset 0 is StrPrint[7:0]. 1 means byte offset 0 is StrPrint[31:24].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- Syscall  in  1  syscall instruction valid in W stage, one-cycle pulse
- V0  in  32  service code, sampled when Syscall=1
- A0  in  32  argument, sampled when Syscall=1
- StrPrintAddr  out  32  word-aligned read address to the memory string port
- StrPrint  in  32  memory read data, combinational from StrPrintAddr in the same cycle
- CharValid  out  1  character available
- CharData  out  8  character byte
- CharReady  in  1  console accepts the character
- IntValid  out  1  integer available
- IntData  out  32  integer value
- IntReady  in  1  console accepts the integer
- Stall  out  1  freeze fetch/decode/execute/memory/writeback registers
- Halt  out  1  program exit, sticky
- BadSyscall  out  1  one-cycle pulse: unsupported V0
- Truncated  out  1  one-cycle pulse: string hit MAX_STR_LEN

Behaviour:
- States: IDLE, INT, CHAR, STR, HALT. Registers: ptr[31:0], arg[31:0], cnt (clog2(MAX_STR_LEN+1) bits).
- Reset (synchronous, dominates all other inputs):
  - Next state is IDLE; ptr, arg and cnt clear to 0.
  - All outputs are 0 the cycle after rst is sampled, including Halt.
  - A reset mid-service drops the service with no further characters or integers; any handshake in flight is abandoned.
- IDLE with Syscall=1, decoded on V0 (full 32-bit compare):
  - 1 → INT, arg=A0.
  - 4 → STR, ptr=A0, cnt=0.
  - 11 → CHAR, arg=A0.
  - 10 → HALT.
  - Any other value: BadSyscall=1 for that cycle, stay in IDLE, no stall.
- Stall is combinational: Stall = (state != IDLE) | (Syscall & V0 in {1,4,10,11} & state == IDLE). It rises in the accept cycle.
- INT: IntValid=1, IntData=arg. On IntValid&IntReady → IDLE. Data stays stable while valid and not ready.
- CHAR: CharValid=1, CharData=arg[7:0]. On CharValid&CharReady → IDLE.
- STR, one byte per cycle:
  - StrPrintAddr={ptr[31:2],2'b00}. The byte is selected by ptr[1:0] per BIG_ENDIAN.
  - Byte == 8'h00: CharValid=0, next state IDLE. The terminator is never emitted.
  - Otherwise CharValid=1, CharData=byte. On CharReady: ptr=ptr+1 (mod 2^32, so 0xFFFFFFFF wraps to 0) and cnt=cnt+1.
  - If cnt+1 == MAX_STR_LEN on that handshake: Truncated=1 that cycle, next state IDLE.
  - Word boundaries need no special handling; the address is recomputed every cycle.
- HALT: Halt=1 and Stall=1 permanently until rst. Syscall is ignored.
- Syscall asserted while state != IDLE is ignored. This cannot occur legally because the pipeline is stalled.
- Outside STR, StrPrintAddr=0. CharData=0 when CharValid=0, and IntData=0 when IntValid=0.
- Minimum latency: print int or char takes 2 stall cycles with ready held high. A string of N characters takes N+2 stall cycles.

Test Plan:
- Int: V0=1, A0=0x0000002A, IntReady=1 → IntValid high for exactly 1 cycle with IntData=0x2A; Stall high for 2 cycles; then IDLE.
- String: mem[0x100]="Hi\0" (BIG_ENDIAN=0, word 0x00006948), V0=4, A0=0x100, CharReady=1 → 'H' (0x48) then 'i' (0x69) on consecutive cycles; Stall high for 4 cycles; 0x00 never emitted.
- Unaligned, backpressure: string "ABC\0" starting at 0x103; CharReady low for 3 cycles on 'A' →
  - StrPrintAddr 0x100 then 0x104.
  - 'A' held stable for 4 cycles, followed by 'B', 'C'.
- Truncation: MAX_STR_LEN=4, string of 10 non-zero bytes → exactly 4 characters emitted; Truncated pulses with the 4th handshake; Stall drops the next cycle.
- Exit and bad code:
  - V0=99 → BadSyscall is a 1-cycle pulse, Stall=0.
  - V0=10 → Halt=1 and Stall=1 sticky for over 20 cycles; a further Syscall has no effect; rst clears both.
- Reset mid-string: rst asserted after the 2nd character of "Hello" → CharValid=0 and Stall=0 from the next cycle; no further characters; the following V0=11, A0=0x21 emits '!' normally.
